// File: rtl/pipe_ctrl_seq_pkg.sv
// Shared definitions for the pipeline control unit: opcode constants, PC
// select encodings, sequencer state/opcode-class enums and the registered
// EX/MEM/WB control bundle.
package pipe_ctrl_seq_pkg;

  // Opcode map of the 5-stage core (6-bit primary opcode field).
  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_DIV     = 6'h1A;
  localparam logic [5:0] OP_MULTYPE = 6'h1C;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_BUSY,
    SEQ_DONE
  } seq_state_e;

  // Which multi-cycle unit (if any) the ID-stage opcode needs.
  typedef enum logic [1:0] {
    OPC_OTHER,
    OPC_DIV,
    OPC_MUL
  } op_class_e;

  typedef struct packed {
    logic alu_src;
    logic reg_dst;
    logic sign_ext;
    logic no_dest;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic iord;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic hilo_write;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_bundle_t;

endpackage

// File: rtl/pipe_ctrl_seq_if.sv
// Control-unit boundary: ID-stage inputs from the IF/ID register and the
// front-end / ID/EX outputs. master = ID stage side, slave = control unit.
interface pipe_ctrl_seq_if #(
  parameter int OPW = 6
);
  // ID-stage inputs
  logic [OPW-1:0] opcode;
  logic           cmp_eq;
  logic [4:0]     id_rs;
  logic [4:0]     id_rt;

  // Front-end control
  logic [1:0]     PCsrc;
  logic           IFflush;
  logic           stall;
  logic           md_start;
  logic           md_busy;

  // Registered ID/EX bundle
  logic           ex_ALUsrc;
  logic           ex_regDst;
  logic           ex_signExt;
  logic           ex_noDest;
  logic [OPW-1:0] ex_opcode;
  logic [4:0]     ex_rt;
  logic           mem_memRead;
  logic           mem_memWrite;
  logic           mem_IorD;
  logic           wb_regWrite;
  logic           wb_memToReg;
  logic           wb_hiloWrite;

  modport master (
    output opcode, cmp_eq, id_rs, id_rt,
    input  PCsrc, IFflush, stall, md_start, md_busy,
    input  ex_ALUsrc, ex_regDst, ex_signExt, ex_noDest, ex_opcode, ex_rt,
    input  mem_memRead, mem_memWrite, mem_IorD,
    input  wb_regWrite, wb_memToReg, wb_hiloWrite
  );

  modport slave (
    input  opcode, cmp_eq, id_rs, id_rt,
    output PCsrc, IFflush, stall, md_start, md_busy,
    output ex_ALUsrc, ex_regDst, ex_signExt, ex_noDest, ex_opcode, ex_rt,
    output mem_memRead, mem_memWrite, mem_IorD,
    output wb_regWrite, wb_memToReg, wb_hiloWrite
  );
endinterface

// File: rtl/pipe_ctrl_seq_md.sv
// md_sequencer: holds the front end for DIV (DIV_CYCLES) or MULTYPE
// (MUL_CYCLES) cycles. The start cycle itself counts as the first stall
// cycle; DONE is the unstalled cycle in which the instruction enters ID/EX.
module md_sequencer
  import pipe_ctrl_seq_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  op_class_e op_class,
  input  logic      hold,
  output logic      md_start,
  output logic      stall_req,
  output logic      md_busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  seq_state_e      state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   load_val;
  logic            start;

  // Remaining stall cycles after the start cycle.
  assign load_val = (op_class == OPC_DIV) ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);

  // A start is deferred (no pulse) while the load-use interlock holds ID,
  // and suppressed while reset is asserted.
  assign start     = (state == SEQ_IDLE) && (op_class != OPC_OTHER) && !hold && !reset;
  assign md_start  = start;
  assign stall_req = start || (state == SEQ_BUSY);

  // Sequencer FSM and down-counter; md_busy tracks "state != IDLE".
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= SEQ_IDLE;
      count   <= '0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            count   <= load_val;
            md_busy <= 1'b1;
            state   <= (load_val != '0) ? SEQ_BUSY : SEQ_DONE;
          end
        end
        SEQ_BUSY: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          state   <= SEQ_IDLE;
          md_busy <= 1'b0;
        end
        default: begin
          state   <= SEQ_IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// pipe_ctrl_seq: ID-stage decode, branch/jump resolution, ID/EX control
// register and front-end stall generation for the 5-stage core.
// Build option: define CTRL_HAZARD_EN to include the load-use interlock;
// without it, stall comes only from the multiply/divide sequencer.
module pipe_ctrl_seq
  import pipe_ctrl_seq_pkg::*;
#(
  parameter int OPW        = 6,
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  pipe_ctrl_seq_if.slave  bus
);

  ctrl_bundle_t   dec;
  pcsrc_e         dec_pcsrc;
  logic           dec_flush;
  op_class_e      op_class;

  ctrl_bundle_t   idex_q;
  logic [OPW-1:0] ex_opcode_q;
  logic [4:0]     ex_rt_q;

  logic           load_use;
  logic           seq_stall;
  logic           seq_start;
  logic           seq_busy;
  logic           stall;

  // Opcode decode into control bundle, redirect and multi-cycle class.
  // NOTE: every output gets a default first so no path through the case leaves a value held, which would infer a latch.
  always_comb begin
    dec       = '0;
    dec_pcsrc = PC_PLUS4;
    dec_flush = 1'b0;
    op_class  = OPC_OTHER;
    case (bus.opcode)
      OPW'(OP_RTYPE): begin
        dec.wb.reg_write = 1'b1;
        dec.ex.reg_dst   = 1'b1;
      end
      OPW'(OP_ADDI), OPW'(OP_ORI): begin
        dec.wb.reg_write = 1'b1;
        dec.ex.alu_src   = 1'b1;
      end
      OPW'(OP_LUI): begin
        dec.wb.reg_write = 1'b1;
        dec.ex.alu_src   = 1'b1;
        dec.ex.sign_ext  = 1'b1;
      end
      OPW'(OP_LW): begin
        dec.wb.reg_write  = 1'b1;
        dec.wb.mem_to_reg = 1'b1;
        dec.mem.iord      = 1'b1;
        dec.mem.mem_read  = 1'b1;
        dec.ex.alu_src    = 1'b1;
      end
      OPW'(OP_SW): begin
        dec.mem.iord      = 1'b1;
        dec.mem.mem_write = 1'b1;
        dec.ex.alu_src    = 1'b1;
      end
      OPW'(OP_J): begin
        dec_pcsrc = PC_JUMP;
      end
      OPW'(OP_JAL): begin
        dec_pcsrc      = PC_JUMP;
        dec.ex.no_dest = 1'b1;
      end
      OPW'(OP_BEQ): begin
        if (bus.cmp_eq) begin
          dec_pcsrc = PC_BRANCH;
          dec_flush = 1'b1;
        end
      end
      OPW'(OP_BNE): begin
        if (!bus.cmp_eq) begin
          dec_pcsrc = PC_BRANCH;
          dec_flush = 1'b1;
        end
      end
      OPW'(OP_DIV): begin
        dec.wb.hilo_write = 1'b1;
        op_class          = OPC_DIV;
      end
      OPW'(OP_MULTYPE): begin
        dec.wb.reg_write = 1'b1;
        dec.ex.reg_dst   = 1'b1;
        op_class         = OPC_MUL;
      end
      default: begin
        dec = '0;
      end
    endcase
  end

`ifdef CTRL_HAZARD_EN
  // Load in EX writing a register the ID instruction reads: one bubble.
  assign load_use = idex_q.mem.mem_read && (ex_rt_q != 5'd0) &&
                    ((ex_rt_q == bus.id_rs) || (ex_rt_q == bus.id_rt));
`else
  // Software fills load delay slots; rs is not needed by the control unit.
  logic unused_id_rs;
  assign unused_id_rs = ^bus.id_rs;
  assign load_use     = 1'b0;
`endif

  md_sequencer #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_md_seq (
    .clock     (clock),
    .reset     (reset),
    .op_class  (op_class),
    .hold      (load_use),
    .md_start  (seq_start),
    .stall_req (seq_stall),
    .md_busy   (seq_busy)
  );

  assign stall = seq_stall || load_use;

  // A stalled instruction must not redirect the PC; it resolves once unstalled.
  assign bus.stall    = stall;
  assign bus.PCsrc    = stall ? PC_PLUS4 : dec_pcsrc;
  assign bus.IFflush  = !stall && dec_flush;
  assign bus.md_start = seq_start;
  assign bus.md_busy  = seq_busy;

  // ID/EX control register: decoded bundle when advancing, bubble when stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idex_q      <= '0;
      ex_opcode_q <= '0;
      ex_rt_q     <= '0;
    end else if (stall) begin
      idex_q      <= '0;
      ex_opcode_q <= '0;
      ex_rt_q     <= '0;
    end else begin
      idex_q      <= dec;
      ex_opcode_q <= bus.opcode;
      ex_rt_q     <= bus.id_rt;
    end
  end

  assign bus.ex_ALUsrc    = idex_q.ex.alu_src;
  assign bus.ex_regDst    = idex_q.ex.reg_dst;
  assign bus.ex_signExt   = idex_q.ex.sign_ext;
  assign bus.ex_noDest    = idex_q.ex.no_dest;
  assign bus.ex_opcode    = ex_opcode_q;
  assign bus.ex_rt        = ex_rt_q;
  assign bus.mem_memRead  = idex_q.mem.mem_read;
  assign bus.mem_memWrite = idex_q.mem.mem_write;
  assign bus.mem_IorD     = idex_q.mem.iord;
  assign bus.wb_regWrite  = idex_q.wb.reg_write;
  assign bus.wb_memToReg  = idex_q.wb.mem_to_reg;
  assign bus.wb_hiloWrite = idex_q.wb.hilo_write;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Testbench for pipe_ctrl_seq. Acts as the front end: each instruction is
// held in ID for as many cycles as the instruction-level model says it
// stalls; the expected per-cycle outputs go into a scoreboard queue that a
// negedge monitor pops and compares.
module tb_pipe_ctrl_seq;
  import pipe_ctrl_seq_pkg::*;

  localparam int OPW   = 6;
  localparam int DIV_N = 32;
  localparam int MUL_N = 1;
`ifdef CTRL_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  typedef struct packed {
    logic        stall;
    logic [1:0]  pcsrc;
    logic        flush;
    logic        md_start;
    logic        md_busy;
    logic [20:0] regs;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipe_ctrl_seq_if #(.OPW(OPW)) bus ();

  pipe_ctrl_seq #(
    .OPW        (OPW),
    .DIV_CYCLES (DIV_N),
    .MUL_CYCLES (MUL_N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  // Model state: what the ID/EX register should hold, and the instruction in EX.
  logic [20:0] m_regs;
  bit          m_last_lw;
  logic [4:0]  m_last_rt;

  logic [20:0] act_regs;
  assign act_regs = {bus.ex_ALUsrc, bus.ex_regDst, bus.ex_signExt, bus.ex_noDest,
                     bus.mem_memRead, bus.mem_memWrite, bus.mem_IorD,
                     bus.wb_regWrite, bus.wb_memToReg, bus.wb_hiloWrite,
                     bus.ex_opcode, bus.ex_rt};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control table, bit order:
  // ALUsrc regDst signExt noDest | memRead memWrite IorD | regWrite memToReg hiloWrite
  function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_MULTYPE: return 10'b0100_000_100;
      OP_ADDI, OP_ORI:      return 10'b1000_000_100;
      OP_LUI:               return 10'b1010_000_100;
      OP_LW:                return 10'b1000_101_110;
      OP_SW:                return 10'b1000_011_000;
      OP_JAL:               return 10'b0001_000_000;
      OP_DIV:               return 10'b0000_000_001;
      default:              return 10'b0000_000_000;
    endcase
  endfunction

  // {PCsrc, IFflush} for an unstalled instruction.
  function automatic logic [2:0] ref_redirect(input logic [5:0] op, input logic cmp);
    if (op == OP_J || op == OP_JAL)   return 3'b01_0;
    if (op == OP_BEQ && cmp)          return 3'b10_1;
    if (op == OP_BNE && !cmp)         return 3'b10_1;
    return 3'b00_0;
  endfunction

  function automatic int md_len(input logic [5:0] op);
    if (op == OP_DIV)     return DIV_N;
    if (op == OP_MULTYPE) return MUL_N;
    return 0;
  endfunction

  // Present one instruction in ID until it issues, queueing expectations.
  task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic cmp);
    int         haz;
    int         nmd;
    int         total;
    exp_t       e;
    logic [2:0] pcf;
    haz   = (HAZ_EN && m_last_lw && m_last_rt != 5'd0 &&
             (m_last_rt == rs || m_last_rt == rt)) ? 1 : 0;
    nmd   = md_len(op);
    total = haz + nmd;
    pcf   = ref_redirect(op, cmp);
    for (int c = 0; c <= total; c++) begin
      @(posedge clock);
      #1;
      bus.opcode = op;
      bus.id_rs  = rs;
      bus.id_rt  = rt;
      bus.cmp_eq = cmp;
      e.stall    = (c != total);
      e.pcsrc    = (c == total) ? pcf[2:1] : 2'b00;
      e.flush    = (c == total) ? pcf[0] : 1'b0;
      e.md_start = (nmd > 0) && (c == haz);
      e.md_busy  = (nmd > 0) && (c > haz);
      e.regs     = m_regs;
      exp_q.push_back(e);
      mon_en     = 1'b1;
      m_regs     = (c == total) ? {ref_ctrl(op), op, rt} : 21'd0;
    end
    m_last_lw = (op == OP_LW);
    m_last_rt = rt;
  endtask

  // Inputs are all zero after reset: an RTYPE with rt=0 registers on the next edge.
  task automatic model_after_reset();
    m_regs    = {ref_ctrl(OP_RTYPE), 6'd0, 5'd0};
    m_last_lw = 1'b0;
    m_last_rt = 5'd0;
  endtask

  task automatic clear_inputs();
    bus.opcode = '0;
    bus.id_rs  = '0;
    bus.id_rt  = '0;
    bus.cmp_eq = 1'b0;
  endtask

  // Scoreboard monitor: compares every cycle away from the rising edge.
  always @(negedge clock) begin
    if (mon_en) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("stall",    32'(bus.stall),    32'(mon_e.stall));
        check("pcsrc",    32'(bus.PCsrc),    32'(mon_e.pcsrc));
        check("ifflush",  32'(bus.IFflush),  32'(mon_e.flush));
        check("md_start", 32'(bus.md_start), 32'(mon_e.md_start));
        check("md_busy",  32'(bus.md_busy),  32'(mon_e.md_busy));
        check("idex",     32'(act_regs),     32'(mon_e.regs));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    int         r;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clock);
    // Reset state with opcode 0
    check("rst_stall",    32'(bus.stall),    32'd0);
    check("rst_md_start", 32'(bus.md_start), 32'd0);
    check("rst_pcsrc",    32'(bus.PCsrc),    32'd0);
    check("rst_ifflush",  32'(bus.IFflush),  32'd0);
    check("rst_md_busy",  32'(bus.md_busy),  32'd0);
    check("rst_idex",     32'(act_regs),     32'd0);
    reset = 1'b0;
    model_after_reset();

    // Directed: multi-cycle ops, branches, load-use, remaining opcodes
    issue(OP_DIV,     5'd1, 5'd2, 1'b0);
    issue(OP_RTYPE,   5'd1, 5'd2, 1'b0);
    issue(OP_MULTYPE, 5'd3, 5'd4, 1'b0);
    issue(OP_RTYPE,   5'd0, 5'd0, 1'b0);
    issue(OP_BEQ,     5'd1, 5'd2, 1'b1);
    issue(OP_BNE,     5'd1, 5'd2, 1'b1);
    issue(OP_BEQ,     5'd1, 5'd2, 1'b0);
    issue(OP_BNE,     5'd1, 5'd2, 1'b0);
    issue(OP_J,       5'd0, 5'd0, 1'b0);
    issue(OP_JAL,     5'd0, 5'd0, 1'b1);
    issue(OP_LW,      5'd1, 5'd5, 1'b0);
    issue(OP_RTYPE,   5'd5, 5'd6, 1'b0);
    issue(OP_LW,      5'd1, 5'd0, 1'b0);
    issue(OP_RTYPE,   5'd0, 5'd0, 1'b0);
    issue(OP_LW,      5'd2, 5'd3, 1'b0);
    issue(OP_DIV,     5'd3, 5'd7, 1'b0);
    issue(OP_LW,      5'd2, 5'd4, 1'b0);
    issue(OP_BEQ,     5'd6, 5'd4, 1'b1);
    issue(OP_ADDI,    5'd1, 5'd8, 1'b0);
    issue(OP_ORI,     5'd2, 5'd9, 1'b0);
    issue(OP_LUI,     5'd0, 5'd10, 1'b0);
    issue(OP_SW,      5'd3, 5'd11, 1'b0);
    issue(6'h3F,      5'd4, 5'd12, 1'b1);
    issue(OP_RTYPE,   5'd0, 5'd0, 1'b0);

    // Reset in the middle of a DIV sequence
    @(negedge clock);
    #1;
    mon_en = 1'b0;
    @(posedge clock);
    #1;
    bus.opcode = OP_DIV;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    #1;
    check("midrst_md_busy",  32'(bus.md_busy),  32'd0);
    check("midrst_stall",    32'(bus.stall),    32'd0);
    check("midrst_md_start", 32'(bus.md_start), 32'd0);
    check("midrst_idex",     32'(act_regs),     32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("postrst_md_busy", 32'(bus.md_busy), 32'd0);
    check("postrst_stall",   32'(bus.stall),   32'd0);
    check("postrst_idex",    32'(act_regs),    32'd0);
    model_after_reset();
    @(negedge clock);
    check("postrst2_stall",   32'(bus.stall),   32'd0);
    check("postrst2_md_busy", 32'(bus.md_busy), 32'd0);
    check("postrst2_idex",    32'(act_regs),    32'(m_regs));

    // Randomized instruction stream with small register numbers for hazards
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 15);
      case (r)
        0:       op = OP_RTYPE;
        1:       op = OP_ADDI;
        2:       op = OP_ORI;
        3:       op = OP_LUI;
        4, 5, 15: op = OP_LW;
        6:       op = OP_SW;
        7:       op = OP_J;
        8:       op = OP_JAL;
        9:       op = OP_BEQ;
        10:      op = OP_BNE;
        11:      op = OP_MULTYPE;
        12:      op = ($urandom_range(0, 3) == 0) ? OP_DIV : OP_RTYPE;
        13:      op = 6'h3F;
        default: op = 6'($urandom_range(0, 63));
      endcase
      issue(op, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    @(negedge clock);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
